cpu_mem_arbiter: RTL and testbench
==================================

# cpu_mem_arbiter

Shares one downstream memory port between the multi-cycle CPU's instruction-fetch channel and its data load/store channel. Sits between the CPU core and the unified memory/cache interface. Sequences each transaction through request and response phases, routes read data back to the requester that issued it, and keeps three 32-bit performance counters for the CPU's perf-counter bank.

## Interface
- `RR_INIT`, default 1: round-robin "last granted" pointer value at reset. 1 means data was last, so instruction wins the first tie.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `inst_addr`  in  32  fetch address (PC)
- `inst_req_valid`  in  1  fetch request
- `inst_req_ready`  out  1  fetch request accepted
- `inst_rdata`  out  32  fetched instruction
- `inst_rvalid`  out  1  instruction valid
- `inst_rready`  in  1  core ready for instruction
- `data_addr`  in  32  word-aligned data address
- `data_wen`  in  1  store request
- `data_ren`  in  1  load request
- `data_wdata`  in  32  store data
- `data_wstrb`  in  4  store byte strobes
- `data_req_ready`  out  1  data request accepted
- `data_rdata`  out  32  load data
- `data_rvalid`  out  1  load data valid
- `data_rready`  in  1  core ready for load data
- `mem_addr`  out  32  downstream address
- `mem_req_valid`  out  1  downstream request
- `mem_we`  out  1  downstream write (1) / read (0)
- `mem_wdata`  out  32  downstream write data
- `mem_wstrb`  out  4  downstream strobes
- `mem_req_ready`  in  1  downstream accepts request
- `mem_rdata`  in  32  downstream read data
- `mem_rvalid`  in  1  downstream read data valid
- `mem_rready`  out  1  arbiter ready for read data
- `cnt_inst`, `cnt_data`, `cnt_conflict`  out  32 each  performance counters

## Operation
- Data request pending = `data_wen | data_ren`. If both are set, treat the request as a write.
- FSM states: IDLE, REQ_I, REQ_D, RSP_I, RSP_D. One-hot encoding.
- IDLE: if exactly one request is pending, go to REQ of that port. If both are pending, grant the port not equal to `last`, then update `last`.
- REQ_x: `mem_req_valid`=1. Address, `mem_we`, wdata and wstrb are muxed combinationally from port x. Port x's req_ready = `mem_req_ready`; the other port's req_ready = 0. On handshake: a read goes to RSP_x; a write (data only) returns to IDLE with no response phase.
- RSP_x: `mem_rready` = port x's rready. Port x's rvalid = `mem_rvalid`, and `mem_rdata` is forwarded to port x. The other port's rvalid = 0. On `mem_rvalid & mem_rready` go to IDLE.
- Requesters hold request fields stable until their req_ready handshake. The arbiter does not register them.
- When the arbiter is not granting a port, `inst_rdata`/`data_rdata` = `mem_rdata`, but both rvalids stay 0.
- Counters:
  - `cnt_inst` increments on each instruction request handshake.
  - `cnt_data` increments on each data request handshake.
  - `cnt_conflict` increments on each IDLE cycle in which both ports are pending.
  - All counters wrap modulo 2^32.

## Timing
- Reset:
  - State goes to IDLE and `last` = `RR_INIT`.
  - All valid/ready outputs = 0.
  - Counters = 0.
  - `mem_addr`, `mem_wdata`, `mem_wstrb` = 0.
  - `mem_we` = 0.
- Reset mid-transaction aborts to IDLE. Any downstream response that arrives afterwards is ignored until a new request is issued. The downstream side is reset by the same `rst`.
- Arbitration costs one cycle: a request seen in IDLE at cycle t presents `mem_req_valid` at t+1.
- Minimum read is 3 cycles (IDLE, REQ, RSP) with ready/rvalid asserted immediately. Minimum write is 2 cycles.
- Back-to-back: after completion the FSM always passes through IDLE, so there is one bubble cycle between transactions.
- A request that drops while in REQ_x is a protocol violation. The behaviour is unspecified, and the bench asserts against it.
- At most one transaction is outstanding at any time.

## Structure
- Shared package `cpu_mem_arb_pkg` holds:
  - state localparams (one-hot, 5 bits)
  - port IDs `PORT_I`=0, `PORT_D`=1
- One sub-module, `arb_rr2`: a 2-way round-robin picker. Inputs are req[1:0] and last. Outputs are the grant one-hot and `conflict`. It is purely combinational; `last` is held in the parent.
- Counters, FSM and muxes live in the top module.

## Test plan
- Single fetch: `inst_req_valid`=1, addr 0x100, ready=1, rvalid one cycle later with rdata 0xDEADBEEF → `inst_rvalid`=1 with 0xDEADBEEF at cycle 3. `cnt_inst`=1, `data_rvalid` stays 0.
- Store: `data_wen`=1, addr 0x200, wstrb 0x3, `mem_req_ready` delayed 4 cycles → `mem_we`=1, strb 0x3 held. `data_req_ready` pulses once, no RSP state, FSM back in IDLE the next cycle.
- Simultaneous after reset: fetch and load both pending → instruction granted first, then data. `cnt_conflict`=1. Repeating the tie grants data first.
- Load with stalled consumer: `mem_rvalid`=1 while `data_rready`=0 for 3 cycles → `mem_rready`=0, FSM held in RSP_D, and the load completes only when rready rises.
- Reset in REQ_D with `mem_req_ready`=0 → next cycle all outputs are at reset values. A subsequent fetch completes normally.
- Counter wrap: preload through 2^32−1 handshakes (force) → `cnt_inst` wraps to 0.

Source files
------------

// File: rtl/cpu_mem_arb_pkg.sv
// Shared types for the CPU instruction/data memory arbiter.
// FSM state encodings are one-hot; port IDs index request/grant vectors.
package cpu_mem_arb_pkg;

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StReqI = 5'b00010,
    StReqD = 5'b00100,
    StRspI = 5'b01000,
    StRspD = 5'b10000
  } arb_state_e;

  localparam int unsigned NUM_STATES = 5;
  localparam int unsigned PORT_I     = 0;
  localparam int unsigned PORT_D     = 1;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bundles the fetch, load/store, downstream memory and perf-counter signals.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface cpu_mem_arbiter_if;

  logic [31:0] inst_addr;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic        inst_rready;

  logic [31:0] data_addr;
  logic        data_wen;
  logic        data_ren;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_req_ready;
  logic [31:0] data_rdata;
  logic        data_rvalid;
  logic        data_rready;

  logic [31:0] mem_addr;
  logic        mem_req_valid;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rready;

  logic [31:0] cnt_inst;
  logic [31:0] cnt_data;
  logic [31:0] cnt_conflict;

  modport slave (
    input  inst_addr, inst_req_valid, inst_rready,
    input  data_addr, data_wen, data_ren, data_wdata, data_wstrb, data_rready,
    input  mem_req_ready, mem_rdata, mem_rvalid,
    output inst_req_ready, inst_rdata, inst_rvalid,
    output data_req_ready, data_rdata, data_rvalid,
    output mem_addr, mem_req_valid, mem_we, mem_wdata, mem_wstrb, mem_rready,
    output cnt_inst, cnt_data, cnt_conflict
  );

  modport master (
    output inst_addr, inst_req_valid, inst_rready,
    output data_addr, data_wen, data_ren, data_wdata, data_wstrb, data_rready,
    output mem_req_ready, mem_rdata, mem_rvalid,
    input  inst_req_ready, inst_rdata, inst_rvalid,
    input  data_req_ready, data_rdata, data_rvalid,
    input  mem_addr, mem_req_valid, mem_we, mem_wdata, mem_wstrb, mem_rready,
    input  cnt_inst, cnt_data, cnt_conflict
  );

endinterface

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker; the last-granted pointer lives
// in the parent so it only advances when the parent decides to.
module arb_rr2
  import cpu_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       conflict
);

  assign conflict = req[PORT_I] & req[PORT_D];

  // last == 1 means data went last, so instruction wins a tie.
  assign grant[PORT_I] = req[PORT_I] & (~req[PORT_D] | last);
  assign grant[PORT_D] = req[PORT_D] & (~req[PORT_I] | ~last);

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store,
// one transaction at a time, with request/response phases and perf counters.
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter bit RR_INIT = 1'b1
) (
  input logic              clk,
  input logic              rst,
  cpu_mem_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] cnt_inst_q, cnt_data_q, cnt_conflict_q;
  logic [1:0]  req, grant;
  logic        conflict;
  logic        data_pend;
  logic        inst_hs, data_hs;

  assign data_pend      = bus.data_wen | bus.data_ren;
  assign req[PORT_I]    = bus.inst_req_valid;
  assign req[PORT_D]    = data_pend;

  arb_rr2 u_rr (
    .req      (req),
    .last     (last_q),
    .grant    (grant),
    .conflict (conflict)
  );

  assign inst_hs = (state_q == StReqI) & bus.mem_req_ready;
  assign data_hs = (state_q == StReqD) & bus.mem_req_ready;

  // Read data is forwarded unconditionally; only rvalid is steered.
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;
  assign bus.cnt_inst     = cnt_inst_q;
  assign bus.cnt_data     = cnt_data_q;
  assign bus.cnt_conflict = cnt_conflict_q;

  always_comb begin
    state_d            = state_q;
    last_d             = last_q;
    bus.inst_req_ready = 1'b0;
    bus.data_req_ready = 1'b0;
    bus.inst_rvalid    = 1'b0;
    bus.data_rvalid    = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_addr       = 32'h0;
    bus.mem_we         = 1'b0;
    bus.mem_wdata      = 32'h0;
    bus.mem_wstrb      = 4'h0;
    bus.mem_rready     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant[PORT_I]) begin
          state_d = StReqI;
        end else if (grant[PORT_D]) begin
          state_d = StReqD;
        end
        // The pointer only moves on a genuine tie.
        if (conflict) begin
          last_d = grant[PORT_D];
        end
      end
      StReqI: begin
        bus.mem_req_valid  = 1'b1;
        bus.mem_addr       = bus.inst_addr;
        bus.inst_req_ready = bus.mem_req_ready;
        if (bus.mem_req_ready) begin
          state_d = StRspI;
        end
      end
      StReqD: begin
        bus.mem_req_valid  = 1'b1;
        bus.mem_addr       = bus.data_addr;
        bus.mem_we         = bus.data_wen;
        bus.mem_wdata      = bus.data_wdata;
        bus.mem_wstrb      = bus.data_wstrb;
        bus.data_req_ready = bus.mem_req_ready;
        if (bus.mem_req_ready) begin
          state_d = bus.data_wen ? StIdle : StRspD;
        end
      end
      StRspI: begin
        bus.mem_rready  = bus.inst_rready;
        bus.inst_rvalid = bus.mem_rvalid;
        if (bus.mem_rvalid & bus.inst_rready) begin
          state_d = StIdle;
        end
      end
      StRspD: begin
        bus.mem_rready  = bus.data_rready;
        bus.data_rvalid = bus.mem_rvalid;
        if (bus.mem_rvalid & bus.data_rready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= RR_INIT;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_inst_q     <= 32'h0;
      cnt_data_q     <= 32'h0;
      cnt_conflict_q <= 32'h0;
    end else begin
      if (inst_hs) begin
        cnt_inst_q <= cnt_inst_q + 32'd1;
      end
      if (data_hs) begin
        cnt_data_q <= cnt_data_q + 32'd1;
      end
      if ((state_q == StIdle) && conflict) begin
        cnt_conflict_q <= cnt_conflict_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: inputs driven on the falling edge,
// outputs sampled 1ns later, expectations hand-computed per scenario.
module tb_cpu_mem_arbiter;
  import cpu_mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter_if bus ();

  cpu_mem_arbiter #(.RR_INIT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Requesters must hold their request until accepted.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!((dut.state_q == StReqI) && !bus.inst_req_valid) &&
              !((dut.state_q == StReqD) && !(bus.data_wen | bus.data_ren)))
      else begin
        $display("FAIL protocol: request dropped in REQ state %b", dut.state_q);
        bad++;
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst                = 1'b1;
    bus.inst_addr      = 32'h0;
    bus.inst_req_valid = 1'b0;
    bus.inst_rready    = 1'b0;
    bus.data_addr      = 32'h0;
    bus.data_wen       = 1'b0;
    bus.data_ren       = 1'b0;
    bus.data_wdata     = 32'h0;
    bus.data_wstrb     = 4'h0;
    bus.data_rready    = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rdata      = 32'h0;
    bus.mem_rvalid     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    total++;
    if (dut.state_q !== StIdle || dut.last_q !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got state=%b last=%b want %b/1",
               dut.state_q, dut.last_q, StIdle);
    end
    total++;
    if ({bus.inst_req_ready, bus.inst_rvalid, bus.data_req_ready, bus.data_rvalid,
         bus.mem_req_valid, bus.mem_rready, bus.mem_we} !== 7'b0) begin
      bad++;
      $display("FAIL reset_handshake: got %b want 0000000",
               {bus.inst_req_ready, bus.inst_rvalid, bus.data_req_ready, bus.data_rvalid,
                bus.mem_req_valid, bus.mem_rready, bus.mem_we});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 68'h0 ||
        {bus.cnt_inst, bus.cnt_data, bus.cnt_conflict} !== 96'h0) begin
      bad++;
      $display("FAIL reset_values: addr=%h wdata=%h strb=%h cnt=%h/%h/%h want all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
               bus.cnt_inst, bus.cnt_data, bus.cnt_conflict);
    end
  endtask

  task automatic test_single_fetch();
    reset_dut();
    bus.inst_req_valid = 1'b1;
    bus.inst_addr      = 32'h100;
    bus.inst_rready    = 1'b1;
    bus.mem_req_ready  = 1'b1;
    #1;
    total++;
    if (bus.mem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL fetch_arb_cycle: got mem_req_valid=%b want 0", bus.mem_req_valid);
    end
    @(negedge clk); #1;
    total++;
    if ({bus.mem_req_valid, bus.inst_req_ready, bus.data_req_ready, bus.mem_we} !== 4'b1100 ||
        bus.mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL fetch_req: got v/ir/dr/we=%b addr=%h want 1100 00000100",
               {bus.mem_req_valid, bus.inst_req_ready, bus.data_req_ready, bus.mem_we},
               bus.mem_addr);
    end
    @(negedge clk);
    bus.inst_req_valid = 1'b0;
    bus.mem_rvalid     = 1'b1;
    bus.mem_rdata      = 32'hDEADBEEF;
    #1;
    total++;
    if ({bus.inst_rvalid, bus.data_rvalid, bus.mem_rready} !== 3'b101 ||
        bus.inst_rdata !== 32'hDEADBEEF || bus.cnt_inst !== 32'd1) begin
      bad++;
      $display("FAIL fetch_rsp: got iv/dv/rr=%b rdata=%h cnt=%0d want 101 deadbeef 1",
               {bus.inst_rvalid, bus.data_rvalid, bus.mem_rready}, bus.inst_rdata,
               bus.cnt_inst);
    end
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    #1;
    total++;
    if (dut.state_q !== StIdle || bus.inst_rvalid !== 1'b0 || bus.cnt_inst !== 32'd1) begin
      bad++;
      $display("FAIL fetch_done: got state=%b iv=%b cnt=%0d want %b 0 1",
               dut.state_q, bus.inst_rvalid, bus.cnt_inst, StIdle);
    end
  endtask

  task automatic test_store();
    int pulses;
    int held_bad;
    reset_dut();
    pulses   = 0;
    held_bad = 0;
    bus.data_wen   = 1'b1;
    bus.data_addr  = 32'h200;
    bus.data_wdata = 32'h12345678;
    bus.data_wstrb = 4'h3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.mem_req_ready = (c == 4);
      #1;
      if (bus.data_req_ready === 1'b1) pulses++;
      if ({bus.mem_req_valid, bus.mem_we} !== 2'b11 || bus.mem_wstrb !== 4'h3 ||
          bus.mem_addr !== 32'h200 || bus.mem_wdata !== 32'h12345678) held_bad++;
    end
    total++;
    if (held_bad != 0) begin
      bad++;
      $display("FAIL store_held: got %0d bad cycles want 0", held_bad);
    end
    @(negedge clk);
    bus.data_wen      = 1'b0;
    bus.mem_req_ready = 1'b0;
    #1;
    if (bus.data_req_ready === 1'b1) pulses++;
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL store_ready_pulse: got %0d pulses want 1", pulses);
    end
    total++;
    if (dut.state_q !== StIdle || bus.mem_req_valid !== 1'b0 || bus.cnt_data !== 32'd1) begin
      bad++;
      $display("FAIL store_done: got state=%b v=%b cnt=%0d want %b 0 1",
               dut.state_q, bus.mem_req_valid, bus.cnt_data, StIdle);
    end
  endtask

  task automatic test_simultaneous();
    reset_dut();
    bus.inst_req_valid = 1'b1;
    bus.inst_addr      = 32'h300;
    bus.data_ren       = 1'b1;
    bus.data_addr      = 32'h400;
    bus.inst_rready    = 1'b1;
    bus.data_rready    = 1'b1;
    bus.mem_req_ready  = 1'b1;
    @(negedge clk); #1;
    total++;
    if (dut.state_q !== StReqI || bus.mem_addr !== 32'h300 ||
        {bus.inst_req_ready, bus.data_req_ready} !== 2'b10 || bus.cnt_conflict !== 32'd1) begin
      bad++;
      $display("FAIL tie1_inst_first: got state=%b addr=%h ir/dr=%b conf=%0d want %b 300 10 1",
               dut.state_q, bus.mem_addr, {bus.inst_req_ready, bus.data_req_ready},
               bus.cnt_conflict, StReqI);
    end
    @(negedge clk);
    bus.inst_req_valid = 1'b0;
    bus.mem_rvalid     = 1'b1;
    bus.mem_rdata      = 32'h0000000A;
    #1;
    total++;
    if ({bus.inst_rvalid, bus.data_rvalid} !== 2'b10) begin
      bad++;
      $display("FAIL tie1_inst_rsp: got iv/dv=%b want 10", {bus.inst_rvalid, bus.data_rvalid});
    end
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    @(negedge clk); #1;
    total++;
    if (dut.state_q !== StReqD || bus.mem_addr !== 32'h400 || bus.mem_we !== 1'b0 ||
        bus.data_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL tie1_data_second: got state=%b addr=%h we=%b dr=%b want %b 400 0 1",
               dut.state_q, bus.mem_addr, bus.mem_we, bus.data_req_ready, StReqD);
    end
    @(negedge clk);
    bus.data_ren   = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000000B;
    #1;
    total++;
    if ({bus.inst_rvalid, bus.data_rvalid} !== 2'b01 || bus.data_rdata !== 32'hB ||
        bus.cnt_conflict !== 32'd1) begin
      bad++;
      $display("FAIL tie1_data_rsp: got iv/dv=%b rdata=%h conf=%0d want 01 0000000b 1",
               {bus.inst_rvalid, bus.data_rvalid}, bus.data_rdata, bus.cnt_conflict);
    end
    @(negedge clk);
    bus.mem_rvalid     = 1'b0;
    bus.inst_req_valid = 1'b1;
    bus.data_ren       = 1'b1;
    @(negedge clk); #1;
    total++;
    if (dut.state_q !== StReqD || bus.mem_addr !== 32'h400 || bus.cnt_conflict !== 32'd2) begin
      bad++;
      $display("FAIL tie2_data_first: got state=%b addr=%h conf=%0d want %b 400 2",
               dut.state_q, bus.mem_addr, bus.cnt_conflict, StReqD);
    end
  endtask

  task automatic test_stalled_load();
    int stall_bad;
    reset_dut();
    stall_bad = 0;
    bus.data_ren      = 1'b1;
    bus.data_addr     = 32'h500;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.data_ren   = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00C0FFEE;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.mem_rready !== 1'b0 || bus.data_rvalid !== 1'b1 || dut.state_q !== StRspD)
        stall_bad++;
      @(negedge clk);
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL load_stall_hold: got %0d bad cycles want 0", stall_bad);
    end
    bus.data_rready = 1'b1;
    #1;
    total++;
    if (bus.mem_rready !== 1'b1 || bus.data_rdata !== 32'h00C0FFEE) begin
      bad++;
      $display("FAIL load_release: got rr=%b rdata=%h want 1 00c0ffee",
               bus.mem_rready, bus.data_rdata);
    end
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    #1;
    total++;
    if (dut.state_q !== StIdle || bus.data_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL load_done: got state=%b dv=%b want %b 0",
               dut.state_q, bus.data_rvalid, StIdle);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    bus.data_wen      = 1'b1;
    bus.data_addr     = 32'h700;
    bus.data_wstrb    = 4'hF;
    bus.data_wdata    = 32'h55AA55AA;
    @(negedge clk); #1;
    total++;
    if (dut.state_q !== StReqD || bus.mem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_in_req: got state=%b v=%b want %b 1",
               dut.state_q, bus.mem_req_valid, StReqD);
    end
    @(negedge clk);
    rst          = 1'b1;
    bus.data_wen = 1'b0;
    @(negedge clk);
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0BAD0;
    bus.inst_rready = 1'b1;
    bus.data_rready = 1'b1;
    #1;
    total++;
    if (dut.state_q !== StIdle ||
        {bus.inst_req_ready, bus.inst_rvalid, bus.data_req_ready, bus.data_rvalid,
         bus.mem_req_valid, bus.mem_rready, bus.mem_we} !== 7'b0 ||
        {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 68'h0 || bus.cnt_data !== 32'd0) begin
      bad++;
      $display("FAIL rstmid_outputs: state=%b hs=%b addr=%h wd=%h st=%h cd=%0d want idle/0",
               dut.state_q,
               {bus.inst_req_ready, bus.inst_rvalid, bus.data_req_ready, bus.data_rvalid,
                bus.mem_req_valid, bus.mem_rready, bus.mem_we},
               bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.cnt_data);
    end
    @(negedge clk);
    bus.mem_rvalid     = 1'b0;
    bus.inst_req_valid = 1'b1;
    bus.inst_addr      = 32'h600;
    bus.mem_req_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.inst_req_valid = 1'b0;
    bus.mem_rvalid     = 1'b1;
    bus.mem_rdata      = 32'h0000600D;
    #1;
    total++;
    if (bus.inst_rvalid !== 1'b1 || bus.inst_rdata !== 32'h600D || bus.cnt_inst !== 32'd1) begin
      bad++;
      $display("FAIL rstmid_refetch: got iv=%b rdata=%h cnt=%0d want 1 0000600d 1",
               bus.inst_rvalid, bus.inst_rdata, bus.cnt_inst);
    end
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_counter_wrap();
    reset_dut();
    force dut.cnt_inst_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_inst_q;
    #1;
    total++;
    if (bus.cnt_inst !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_preload: got %h want ffffffff", bus.cnt_inst);
    end
    @(negedge clk);
    bus.inst_req_valid = 1'b1;
    bus.inst_addr      = 32'h800;
    bus.inst_rready    = 1'b1;
    bus.mem_req_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.inst_req_valid = 1'b0;
    #1;
    total++;
    if (bus.cnt_inst !== 32'h0 || dut.state_q !== StRspI) begin
      bad++;
      $display("FAIL wrap_to_zero: got cnt=%h state=%b want 00000000 %b",
               bus.cnt_inst, dut.state_q, StRspI);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_stalled_load();
    test_reset_mid();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
